// File: rtl/cache_controller_pkg.sv
// Shared types and default field widths for the cache controller slice.
package cache_controller_pkg;

    localparam int unsigned DefTagSize    = 5;
    localparam int unsigned DefIndexSize  = 8;
    localparam int unsigned DefOffsetSize = 2;
    localparam int unsigned DefDataWidth  = 32;
    localparam int unsigned ChannelWidth  = 2;
    localparam int unsigned NumChannels   = 4;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StFlush,
        StFill,
        StUpdate,
        StRespond
    } state_e;

endpackage

// File: rtl/cache_controller_if.sv
// CPU, tag-store, data-array and main-memory signals of the cache controller.
interface cache_controller_if import cache_controller_pkg::*; #(
    parameter int unsigned TAG_SIZE    = DefTagSize,
    parameter int unsigned INDEX_SIZE  = DefIndexSize,
    parameter int unsigned OFFSET_SIZE = DefOffsetSize,
    parameter int unsigned DATA_WIDTH  = DefDataWidth
);
    localparam int unsigned AddrWidth = TAG_SIZE + INDEX_SIZE + OFFSET_SIZE;

    logic                    cpu_req;
    logic                    cpu_we;
    logic [AddrWidth-1:0]    cpu_addr;
    logic [DATA_WIDTH-1:0]   cpu_wdata;
    logic                    cpu_ready;
    logic [DATA_WIDTH-1:0]   cpu_rdata;

    logic [TAG_SIZE-1:0]     tag;
    logic [INDEX_SIZE-1:0]   index;
    logic                    rewrite_tag;
    logic                    is_hit;
    logic                    need_use_fifo;
    logic [ChannelWidth-1:0] channel;
    logic [ChannelWidth-1:0] fifo_channel;
    logic [TAG_SIZE-1:0]     fifo_tag_for_flush;

    logic                    data_we;
    logic [ChannelWidth-1:0] data_channel;
    logic [OFFSET_SIZE-1:0]  data_offset;
    logic [DATA_WIDTH-1:0]   data_wdata;
    logic [DATA_WIDTH-1:0]   data_rdata;

    logic                    mem_req;
    logic                    mem_we;
    logic [AddrWidth-1:0]    mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH-1:0]   mem_rdata;
    logic                    mem_ack;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  is_hit, need_use_fifo, channel, fifo_channel, fifo_tag_for_flush,
        input  data_rdata, mem_rdata, mem_ack,
        output cpu_ready, cpu_rdata, tag, index, rewrite_tag,
        output data_we, data_channel, data_offset, data_wdata,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output is_hit, need_use_fifo, channel, fifo_channel, fifo_tag_for_flush,
        output data_rdata, mem_rdata, mem_ack,
        input  cpu_ready, cpu_rdata, tag, index, rewrite_tag,
        input  data_we, data_channel, data_offset, data_wdata,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/cache_dirty_bits.sv
// Per-set, per-channel dirty flags with independent set, clear and read ports.
module cache_dirty_bits import cache_controller_pkg::*; #(
    parameter int unsigned INDEX_SIZE = DefIndexSize
) (
    input  logic                    clk,
    input  logic                    not_reset,
    input  logic                    set_en,
    input  logic [INDEX_SIZE-1:0]   set_index,
    input  logic [ChannelWidth-1:0] set_channel,
    input  logic                    clr_en,
    input  logic [INDEX_SIZE-1:0]   clr_index,
    input  logic [ChannelWidth-1:0] clr_channel,
    input  logic [INDEX_SIZE-1:0]   rd_index,
    input  logic [ChannelWidth-1:0] rd_channel,
    output logic                    rd_dirty
);
    localparam int unsigned NumSets = 2 ** INDEX_SIZE;

    logic [NumChannels-1:0] dirty_q [NumSets];

    always_ff @(posedge clk or negedge not_reset) begin
        if (!not_reset) begin
            for (int i = 0; i < NumSets; i++) begin
                dirty_q[i] <= '0;
            end
        end else begin
            if (set_en) begin
                dirty_q[set_index][set_channel] <= 1'b1;
            end
            if (clr_en) begin
                dirty_q[clr_index][clr_channel] <= 1'b0;
            end
        end
    end

    assign rd_dirty = dirty_q[rd_index][rd_channel];

endmodule

// File: rtl/cache_controller.sv
// Write-back cache controller: lookup, victim flush, line fill and tag update sequencing.
module cache_controller import cache_controller_pkg::*; #(
    parameter int unsigned TAG_SIZE    = DefTagSize,
    parameter int unsigned INDEX_SIZE  = DefIndexSize,
    parameter int unsigned OFFSET_SIZE = DefOffsetSize,
    parameter int unsigned DATA_WIDTH  = DefDataWidth
) (
    input logic               clk,
    input logic               not_reset,
    cache_controller_if.slave bus
);
    localparam int unsigned AddrWidth = TAG_SIZE + INDEX_SIZE + OFFSET_SIZE;

    state_e                  state_q, state_d;
    logic                    we_q, we_d;
    logic [AddrWidth-1:0]    addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [ChannelWidth-1:0] victim_q, victim_d;
    logic [ChannelWidth-1:0] hit_ch_q, hit_ch_d;
    logic [OFFSET_SIZE-1:0]  word_cnt_q, word_cnt_d;

    logic [TAG_SIZE-1:0]     req_tag;
    logic [INDEX_SIZE-1:0]   req_index;
    logic [OFFSET_SIZE-1:0]  req_offset;
    logic                    last_word;
    logic                    victim_dirty;
    logic                    dirty_set;
    logic                    dirty_clr;

    assign req_tag    = addr_q[AddrWidth-1 -: TAG_SIZE];
    assign req_index  = addr_q[OFFSET_SIZE +: INDEX_SIZE];
    assign req_offset = addr_q[OFFSET_SIZE-1:0];
    assign last_word  = &word_cnt_q;

    assign bus.tag       = req_tag;
    assign bus.index     = req_index;
    assign bus.mem_wdata = bus.data_rdata;

    cache_dirty_bits #(
        .INDEX_SIZE (INDEX_SIZE)
    ) u_dirty (
        .clk         (clk),
        .not_reset   (not_reset),
        .set_en      (dirty_set),
        .set_index   (req_index),
        .set_channel (bus.channel),
        .clr_en      (dirty_clr),
        .clr_index   (req_index),
        .clr_channel (victim_q),
        .rd_index    (req_index),
        .rd_channel  (bus.fifo_channel),
        .rd_dirty    (victim_dirty)
    );

    always_ff @(posedge clk or negedge not_reset) begin
        if (!not_reset) begin
            state_q    <= StIdle;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            victim_q   <= '0;
            hit_ch_q   <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            victim_q   <= victim_d;
            hit_ch_q   <= hit_ch_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        victim_d   = victim_q;
        hit_ch_d   = hit_ch_q;
        word_cnt_d = word_cnt_q;

        bus.cpu_ready    = 1'b0;
        bus.cpu_rdata    = rdata_q;
        bus.rewrite_tag  = 1'b0;
        bus.data_we      = 1'b0;
        bus.data_channel = hit_ch_q;
        bus.data_offset  = req_offset;
        bus.data_wdata   = wdata_q;
        bus.mem_req      = 1'b0;
        bus.mem_we       = 1'b0;
        bus.mem_addr     = {req_tag, req_index, word_cnt_q};
        dirty_set        = 1'b0;
        dirty_clr        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.cpu_req) begin
                    we_d    = bus.cpu_we;
                    addr_d  = bus.cpu_addr;
                    wdata_d = bus.cpu_wdata;
                    state_d = StLookup;
                end
            end
            StLookup: begin
                if (bus.is_hit) begin
                    hit_ch_d         = bus.channel;
                    bus.data_channel = bus.channel;
                    if (we_q) begin
                        bus.data_we = 1'b1;
                        dirty_set   = 1'b1;
                    end
                    state_d = StRespond;
                end else begin
                    victim_d   = bus.fifo_channel;
                    word_cnt_d = '0;
                    state_d    = (bus.need_use_fifo && victim_dirty) ? StFlush : StFill;
                end
            end
            StFlush: begin
                bus.mem_req      = 1'b1;
                bus.mem_we       = 1'b1;
                bus.mem_addr     = {bus.fifo_tag_for_flush, req_index, word_cnt_q};
                bus.data_channel = victim_q;
                bus.data_offset  = word_cnt_q;
                if (bus.mem_ack) begin
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (last_word) begin
                        state_d = StFill;
                    end
                end
            end
            StFill: begin
                bus.mem_req      = 1'b1;
                bus.data_channel = victim_q;
                bus.data_offset  = word_cnt_q;
                bus.data_wdata   = bus.mem_rdata;
                if (bus.mem_ack) begin
                    bus.data_we = 1'b1;
                    word_cnt_d  = word_cnt_q + 1'b1;
                    if (last_word) begin
                        state_d = StUpdate;
                    end
                end
            end
            StUpdate: begin
                // The re-lookup that follows hits and applies any pending write.
                bus.rewrite_tag = 1'b1;
                dirty_clr       = 1'b1;
                state_d         = StLookup;
            end
            StRespond: begin
                bus.cpu_ready = 1'b1;
                bus.cpu_rdata = bus.data_rdata;
                rdata_d       = bus.data_rdata;
                state_d       = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a behavioural data array and memory responder.
module tb_cache_controller;

    logic clk = 1'b0;
    logic not_reset;

    always #5 clk = ~clk;

    cache_controller_if bus ();

    cache_controller dut (
        .clk       (clk),
        .not_reset (not_reset),
        .bus       (bus)
    );

    logic [31:0] dmem [4][256][4];
    logic        pre_we;
    logic [1:0]  pre_ch;
    logic [7:0]  pre_idx;
    logic [1:0]  pre_off;
    logic [31:0] pre_data;

    always @(posedge clk) begin
        if (pre_we) begin
            dmem[pre_ch][pre_idx][pre_off] <= pre_data;
        end else if (bus.data_we) begin
            dmem[bus.data_channel][bus.index][bus.data_offset] <= bus.data_wdata;
        end
    end

    assign bus.data_rdata = dmem[bus.data_channel][bus.index][bus.data_offset];

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [1:0] ch, input logic [7:0] idx, input logic [1:0] off,
                           input logic [31:0] data);
        pre_we   = 1'b1;
        pre_ch   = ch;
        pre_idx  = idx;
        pre_off  = off;
        pre_data = data;
        step();
        pre_we   = 1'b0;
    endtask

    task automatic issue(input logic we, input logic [14:0] addr, input logic [31:0] wd);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wd;
        step();
        bus.cpu_req   = 1'b0;
    endtask

    initial begin
        not_reset              = 1'b0;
        pre_we                 = 1'b0;
        pre_ch                 = '0;
        pre_idx                = '0;
        pre_off                = '0;
        pre_data               = '0;
        bus.cpu_req            = 1'b0;
        bus.cpu_we             = 1'b0;
        bus.cpu_addr           = '0;
        bus.cpu_wdata          = '0;
        bus.is_hit             = 1'b0;
        bus.need_use_fifo      = 1'b0;
        bus.channel            = '0;
        bus.fifo_channel       = '0;
        bus.fifo_tag_for_flush = '0;
        bus.mem_rdata          = '0;
        bus.mem_ack            = 1'b0;
        #2;

        chk("rst_cpu_ready", 32'(bus.cpu_ready), 32'd0);
        chk("rst_rewrite_tag", 32'(bus.rewrite_tag), 32'd0);
        chk("rst_data_we", 32'(bus.data_we), 32'd0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_cpu_rdata", bus.cpu_rdata, 32'd0);

        preload(2'd2, 8'h48, 2'd3, 32'hCAFE_0123);
        preload(2'd3, 8'h12, 2'd0, 32'h3120_0000);
        preload(2'd3, 8'h12, 2'd2, 32'h3120_0002);
        preload(2'd3, 8'h12, 2'd3, 32'h3120_0003);
        not_reset = 1'b1;
        step();

        // Read hit at 0x0123: tag 0, index 0x48, offset 3, channel 2.
        issue(1'b0, 15'h0123, 32'd0);
        bus.is_hit  = 1'b1;
        bus.channel = 2'd2;
        #1;
        chk("hit_tag", 32'(bus.tag), 32'd0);
        chk("hit_index", 32'(bus.index), 32'h48);
        chk("hit_data_channel", 32'(bus.data_channel), 32'd2);
        chk("hit_ready_c1", 32'(bus.cpu_ready), 32'd0);
        chk("hit_mem_req_c1", 32'(bus.mem_req), 32'd0);
        chk("hit_data_we_c1", 32'(bus.data_we), 32'd0);
        step();
        bus.is_hit = 1'b0;
        #1;
        chk("hit_ready_c2", 32'(bus.cpu_ready), 32'd1);
        chk("hit_rdata", bus.cpu_rdata, 32'hCAFE_0123);
        chk("hit_mem_req_c2", 32'(bus.mem_req), 32'd0);
        step();
        #1;
        chk("hit_ready_c3", 32'(bus.cpu_ready), 32'd0);
        chk("hit_rdata_held", bus.cpu_rdata, 32'hCAFE_0123);

        // Clean read miss at 0x0121 into victim channel 1.
        issue(1'b0, 15'h0121, 32'd0);
        bus.need_use_fifo = 1'b0;
        bus.fifo_channel  = 2'd1;
        #1;
        chk("miss_lookup_mem_req", 32'(bus.mem_req), 32'd0);
        step();
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("fill_mem_req", 32'(bus.mem_req), 32'd1);
            chk("fill_mem_we", 32'(bus.mem_we), 32'd0);
            chk("fill_mem_addr", 32'(bus.mem_addr), 32'h120 + 32'(k));
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = 32'hF000_0000 + 32'(k);
            #1;
            chk("fill_data_we", 32'(bus.data_we), 32'd1);
            chk("fill_data_channel", 32'(bus.data_channel), 32'd1);
            chk("fill_data_offset", 32'(bus.data_offset), 32'(k));
            chk("fill_data_wdata", bus.data_wdata, 32'hF000_0000 + 32'(k));
            step();
            bus.mem_ack = 1'b0;
        end
        #1;
        chk("update_rewrite_tag", 32'(bus.rewrite_tag), 32'd1);
        chk("update_mem_req", 32'(bus.mem_req), 32'd0);
        bus.is_hit  = 1'b1;
        bus.channel = 2'd1;
        step();
        #1;
        chk("relookup_rewrite_tag", 32'(bus.rewrite_tag), 32'd0);
        chk("relookup_ready", 32'(bus.cpu_ready), 32'd0);
        step();
        bus.is_hit = 1'b0;
        #1;
        chk("miss_ready", 32'(bus.cpu_ready), 32'd1);
        chk("miss_rdata", bus.cpu_rdata, 32'hF000_0001);
        step();

        // Write hit at 0x0849: tag 2, index 0x12, offset 1, channel 3.
        issue(1'b1, 15'h0849, 32'hDEAD_BEEF);
        bus.is_hit  = 1'b1;
        bus.channel = 2'd3;
        #1;
        chk("wr_hit_data_we", 32'(bus.data_we), 32'd1);
        chk("wr_hit_channel", 32'(bus.data_channel), 32'd3);
        chk("wr_hit_offset", 32'(bus.data_offset), 32'd1);
        chk("wr_hit_wdata", bus.data_wdata, 32'hDEAD_BEEF);
        step();
        bus.is_hit = 1'b0;
        #1;
        chk("wr_hit_ready", 32'(bus.cpu_ready), 32'd1);
        chk("wr_hit_rdata", bus.cpu_rdata, 32'hDEAD_BEEF);
        step();

        // Dirty victim: miss at 0x0C4A (tag 3, index 0x12), victim channel 3 holds tag 0x07.
        issue(1'b0, 15'h0C4A, 32'd0);
        bus.need_use_fifo      = 1'b1;
        bus.fifo_channel       = 2'd3;
        bus.fifo_tag_for_flush = 5'h07;
        #1;
        chk("dirty_lookup_mem_req", 32'(bus.mem_req), 32'd0);
        step();
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("flush_mem_req", 32'(bus.mem_req), 32'd1);
            chk("flush_mem_we", 32'(bus.mem_we), 32'd1);
            chk("flush_mem_addr", 32'(bus.mem_addr), 32'h1C48 + 32'(k));
            chk("flush_data_channel", 32'(bus.data_channel), 32'd3);
            chk("flush_mem_wdata", bus.mem_wdata,
                (k == 1) ? 32'hDEAD_BEEF : 32'h3120_0000 + 32'(k));
            bus.mem_ack = 1'b1;
            step();
            bus.mem_ack = 1'b0;
        end
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("refill_mem_we", 32'(bus.mem_we), 32'd0);
            chk("refill_mem_addr", 32'(bus.mem_addr), 32'hC48 + 32'(k));
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = 32'hA000_0000 + 32'(k);
            step();
            bus.mem_ack = 1'b0;
        end
        #1;
        chk("dirty_update_rewrite_tag", 32'(bus.rewrite_tag), 32'd1);
        bus.is_hit  = 1'b1;
        bus.channel = 2'd3;
        step();
        step();
        bus.is_hit        = 1'b0;
        bus.need_use_fifo = 1'b0;
        #1;
        chk("dirty_miss_ready", 32'(bus.cpu_ready), 32'd1);
        chk("dirty_miss_rdata", bus.cpu_rdata, 32'hA000_0002);
        step();

        // Write hit at 0x0480 (index 0x20, channel 0) leaves a dirty bit for the reset check.
        issue(1'b1, 15'h0480, 32'h1234_5678);
        bus.is_hit  = 1'b1;
        bus.channel = 2'd0;
        #1;
        chk("wr_hit2_data_we", 32'(bus.data_we), 32'd1);
        step();
        bus.is_hit = 1'b0;
        step();

        // Index 0x12 channel 3 was cleaned by the update, so this miss must skip the flush.
        issue(1'b0, 15'h1048, 32'd0);
        bus.need_use_fifo = 1'b1;
        bus.fifo_channel  = 2'd3;
        step();
        #1;
        chk("cleaned_victim_mem_we", 32'(bus.mem_we), 32'd0);
        chk("cleaned_victim_mem_addr", 32'(bus.mem_addr), 32'h1048);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h5555_0000;
        step();
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_mem_req", 32'(bus.mem_req), 32'd1);
            chk("stall_mem_addr", 32'(bus.mem_addr), 32'h1049);
            step();
        end
        not_reset = 1'b0;
        #1;
        chk("midburst_rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("midburst_rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("midburst_rst_cpu_ready", 32'(bus.cpu_ready), 32'd0);
        chk("midburst_rst_data_we", 32'(bus.data_we), 32'd0);
        chk("midburst_rst_cpu_rdata", bus.cpu_rdata, 32'd0);
        step();
        not_reset = 1'b1;
        step();
        #1;
        chk("post_rst_idle_ready", 32'(bus.cpu_ready), 32'd0);
        chk("post_rst_idle_mem_req", 32'(bus.mem_req), 32'd0);

        // Reset cleared dirty[0x20][0]: a replacing miss there goes straight to fill.
        issue(1'b0, 15'h1480, 32'd0);
        bus.need_use_fifo = 1'b1;
        bus.fifo_channel  = 2'd0;
        step();
        #1;
        chk("rst_dirty_clear_mem_req", 32'(bus.mem_req), 32'd1);
        chk("rst_dirty_clear_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_dirty_clear_mem_addr", 32'(bus.mem_addr), 32'h1480);
        not_reset = 1'b0;
        #1;
        chk("final_rst_mem_req", 32'(bus.mem_req), 32'd0);
        step();
        not_reset = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
